fast_arc_detect: RTL
====================

Name: fast_arc_detect

Overview:
- Consumes the 16-bit packed ring word produced by the comparator-packing stage of the FAST front-end.
  - Bit 15 is ring position 0 (pixel 0 comparison); bit 0 is ring position 15.
- Finds the longest circular run of consecutive 1s and flags a corner when the run reaches ARC_LEN.
- Keeps a saturating per-frame corner count for the keypoint selector.
- Three-stage pipeline with valid/ready handshake on both sides.

Parameters:
- ARC_LEN, 9, minimum contiguous arc length that qualifies a corner; legal range 1..16.
- CNT_W, 16, width of corner_count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  in_bits valid this cycle.
- in_ready  output  1  block accepts in_bits this cycle.
- in_bits  input  16  packed ring word; bit 15 = position 0, bit 0 = position 15.
- frame_start  input  1  single-cycle pulse; clears the frame statistics.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- max_run  output  5  longest circular run of 1s, 0..16.
- is_corner  output  1  max_run >= ARC_LEN.
- corner_count  output  CNT_W  corners accepted since the last frame_start or reset.
- count_sat  output  1  sticky flag; corner_count saturated this frame.

Behaviour:
- Reset (reset=0 at a clk edge):
  - all stage valids, out_valid, max_run, is_corner, corner_count and count_sat go to 0;
  - in_ready is 1 on the first cycle after reset;
  - a reset mid-stream discards all in-flight words.
- Handshake and stalling:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - While adv=0 every stage holds its contents; no word is lost or duplicated, and order is preserved.
  - out_valid and the result outputs stay stable until the output transfer completes.
- Latency: 3 cycles from the input transfer to out_valid with no stall.
  - S1: register in_bits.
  - S2: per-position run lengths over the doubled (32-bit) ring.
  - S3: maximum reduction plus the compare against ARC_LEN.
  - Throughput is 1 word/cycle.
- Run rules:
  - Adjacency is circular: position 15 (bit 0) neighbours position 0 (bit 15).
  - All-ones gives max_run=16, not 32.
  - All-zeros gives max_run=0.
- Counter:
  - On an output transfer with is_corner=1, corner_count increments.
  - At all-ones the counter holds its value and count_sat is set to 1.
  - frame_start clears corner_count and count_sat.
  - If frame_start coincides with a corner transfer, the transfer counts toward the new frame (corner_count=1).
  - frame_start does not flush the pipeline.
- Inputs sampled while in_valid=0 have no effect.

Decomposition:
- Package fast_pkg:
  - RING_N=16 and RUN_W=5;
  - a function mapping ring position to bit index (15-p).
- One sub-module, ring_run_len: combinational, 16-bit ring in, 5-bit max circular run out. It is instantiated across S2/S3 with registers in the parent.

Test Plan:
- Zero and full ring: in_bits=0x0000 → 3 cycles later out_valid=1, max_run=0, is_corner=0. Then in_bits=0xFFFF → max_run=16, is_corner=1.
- Threshold edge:
  - in_bits=0xFF80 (positions 0–8) → max_run=9, is_corner=1.
  - in_bits=0xFF00 → max_run=8, is_corner=0.
  - in_bits=0xAAAA → max_run=1, is_corner=0.
- Wrap-around: in_bits=0xF01F (positions 0–3 and 11–15) → max_run=9, is_corner=1. in_bits=0x8001 → max_run=2.
- Backpressure: stream 8 back-to-back words with out_ready held low for cycles 4–8 → in_ready drops while out_valid=1; all 8 results emerge in order with no duplicates.
- Saturation (CNT_W=4): 16 corner words accepted → corner_count=15, count_sat=1. A frame_start pulse → corner_count=0, count_sat=0. frame_start coincident with a corner transfer → corner_count=1.
- Reset mid-stream: assert reset=0 for 1 cycle with 3 words in flight → out_valid=0 and corner_count=0 next cycle; no stale results emerge.

Source files
------------

// File: rtl/fast_arc_detect_pkg.sv
// Shared constants and helpers for the FAST arc detector.
package fast_pkg;

    localparam int RING_N = 16;
    localparam int RUN_W  = 5;

    // Ring position p lives at bit index 15-p of the packed word.
    function automatic logic [3:0] pos_to_bit(input int p);
        return 4'(RING_N - 1 - p);
    endfunction

endpackage

// File: rtl/fast_arc_detect_if.sv
// Stream interface of the arc detector: ring words in, run/corner results out.
interface fast_arc_detect_if #(
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_bits;
    logic              frame_start;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        max_run;
    logic              is_corner;
    logic [CNT_W-1:0]  corner_count;
    logic              count_sat;

    modport slave (
        input  in_valid, in_bits, frame_start, out_ready,
        output in_ready, out_valid, max_run, is_corner, corner_count, count_sat
    );

    modport master (
        output in_valid, in_bits, frame_start, out_ready,
        input  in_ready, out_valid, max_run, is_corner, corner_count, count_sat
    );
endinterface

// File: rtl/fast_arc_detect_ring_run_len.sv
// Longest circular run of 1s in a 16-position ring (combinational).
module ring_run_len
    import fast_pkg::*;
(
    input  logic [15:0]      ring,
    output logic [RUN_W-1:0] run
);

    logic [5:0] cur_s;
    logic [5:0] best_s;

    // Scan the doubled ring so a run crossing position 15 -> 0 is seen whole.
    always_comb begin
        cur_s  = 6'd0;
        best_s = 6'd0;
        for (int i = 0; i < 2 * RING_N; i++) begin
            if (ring[pos_to_bit(i % RING_N)]) begin
                cur_s = cur_s + 6'd1;
            end else begin
                cur_s = 6'd0;
            end
            best_s = (cur_s > best_s) ? cur_s : best_s;
        end
        if (ring == {RING_N{1'b1}}) begin
            run = 5'd16;
        end else begin
            run = best_s[RUN_W-1:0];
        end
    end

endmodule

// File: rtl/fast_arc_detect.sv
// FAST arc detector: three-stage pipeline finding the longest circular arc of
// brighter/darker pixels, flagging corners and counting them per frame.
module fast_arc_detect
    import fast_pkg::*;
#(
    parameter int ARC_LEN = 9,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    fast_arc_detect_if.slave bus
);

    localparam logic [RUN_W-1:0] ARC_RUN = RUN_W'(ARC_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              adv_s;
    logic              corner_xfer_s;
    logic [RUN_W-1:0]  run_s;

    logic              s1_valid_r;
    logic [15:0]       s1_word_r;
    logic              s2_valid_r;
    logic [RUN_W-1:0]  s2_run_r;
    logic              out_valid_r;
    logic [RUN_W-1:0]  max_run_r;
    logic              is_corner_r;
    logic [CNT_W-1:0]  count_r;
    logic              sat_r;

    // The whole pipe moves together; it only freezes when a result is stuck.
    assign adv_s         = !out_valid_r || bus.out_ready;
    assign corner_xfer_s = out_valid_r && bus.out_ready && is_corner_r;

    ring_run_len u_run (
        .ring (s1_word_r),
        .run  (run_s)
    );

    // Pipeline stages S1 (word), S2 (run length), S3 (result + threshold).
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_r  <= 1'b0;
            s1_word_r   <= 16'h0000;
            s2_valid_r  <= 1'b0;
            s2_run_r    <= 5'd0;
            out_valid_r <= 1'b0;
            max_run_r   <= 5'd0;
            is_corner_r <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r  <= bus.in_valid;
            s1_word_r   <= bus.in_bits;
            s2_valid_r  <= s1_valid_r;
            s2_run_r    <= run_s;
            out_valid_r <= s2_valid_r;
            max_run_r   <= s2_run_r;
            is_corner_r <= (s2_run_r >= ARC_RUN);
        end else begin
            s1_valid_r  <= s1_valid_r;
            s1_word_r   <= s1_word_r;
            s2_valid_r  <= s2_valid_r;
            s2_run_r    <= s2_run_r;
            out_valid_r <= out_valid_r;
            max_run_r   <= max_run_r;
            is_corner_r <= is_corner_r;
        end
    end

    // Per-frame saturating corner counter; a corner leaving together with
    // frame_start belongs to the new frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (bus.frame_start) begin
            count_r <= corner_xfer_s ? CNT_ONE : {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (corner_xfer_s) begin
            if (count_r == CNT_MAX) begin
                count_r <= count_r;
                sat_r   <= 1'b1;
            end else begin
                count_r <= count_r + CNT_ONE;
                sat_r   <= sat_r;
            end
        end else begin
            count_r <= count_r;
            sat_r   <= sat_r;
        end
    end

    assign bus.in_ready     = adv_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.max_run      = max_run_r;
    assign bus.is_corner    = is_corner_r;
    assign bus.corner_count = count_r;
    assign bus.count_sat    = sat_r;

endmodule
